ghost_mode_timer: RTL
=====================

// Module: ghost_mode_timer
// PURPOSE
// Upstream mode sequencer for ghost_mode. Produces the 2-bit GhostMode code
// (00 jail-exit, 01 scatter, 10 chase, 11 return-to-jail) from per-second timers
// and game events, plus a frightened overlay flag and a direction-reverse pulse.
// GhostMode feeds ghost_mode directly; frightened/mode_changed go to ghost AI.
// PARAMETERS
// TICKS_PER_SEC  50_000_000  clk_50mhz cycles per timer second (bench uses 4)
// JAIL_SEC       3           seconds in JAIL before release
// SCATTER_SEC    7           scatter length, level 0
// SCATTER_SEC_L1 5           scatter length, level 1
// CHASE_SEC      20          chase length per phase
// FRIGHT_SEC     6           frightened length, level 0
// FRIGHT_SEC_L1  3           frightened length, level 1
// NUM_PAIRS      4           scatter/chase pairs before permanent chase
// PORTS
// clk_50mhz     in   1  system clock
// reset         in   1  asynchronous, active-high reset
// game_start    in   1  1-cycle pulse: start/restart round; samples level
// level         in   1  0/1 map level
// power_pellet  in   1  1-cycle pulse: Pac-Man ate energizer
// ghost_eaten   in   1  1-cycle pulse: Pac-Man collided with this ghost
// ghost_in_jail in   1  level: ghost occupies jail tile
// pacman_died   in   1  1-cycle pulse: life lost
// GhostMode     out  2  mode code to ghost_mode
// frightened    out  1  frightened overlay active
// mode_changed  out  1  1-cycle pulse: ghosts reverse direction
// phase         out  4  schedule index 0..2*NUM_PAIRS (even=scatter, odd=chase)
// BEHAVIOUR
// - One clock, asynchronous active-high reset; one synchronous always block per register set.
// - Reset: state IDLE, GhostMode 00, frightened 0, mode_changed 0, phase 0, all counters 0.
// - All outputs registered: reflect an input sampled at edge N from edge N onward (1-cycle latency).
// - Prescaler 0..TICKS_PER_SEC-1 emits sec_tick at terminal count; cleared on every state entry
//   and fright start, so a state of L seconds lasts exactly L*TICKS_PER_SEC cycles.
// - States: IDLE(00) JAIL(00) SCATTER(01) CHASE(10) RETURN(11).
// - IDLE: ignore all inputs except game_start -> JAIL, phase 0, level latched.
// - JAIL: after JAIL_SEC -> SCATTER if phase even and < 2*NUM_PAIRS, else CHASE.
// - SCATTER/CHASE: sec counter runs unless frightened; at expiry phase+1, toggle mode,
//   mode_changed=1 for one cycle. phase saturates at 2*NUM_PAIRS => CHASE forever, no timer.
// - Scatter length SCATTER_SEC or SCATTER_SEC_L1 by latched level; same for fright.
// - power_pellet in SCATTER/CHASE: frightened=1, fright counter (re)loaded, mode_changed pulse,
//   schedule counter frozen; ignored in IDLE/JAIL/RETURN.
// - Fright expiry: frightened=0, schedule counter resumes from frozen value; no pulse.
// - ghost_eaten while frightened -> RETURN, frightened=0; schedule counter and phase stay frozen.
//   ghost_eaten while not frightened: ignored.
// - RETURN: hold until ghost_in_jail=1 -> JAIL (full JAIL_SEC) -> resume saved mode per phase
//   with the remaining frozen scatter/chase time.
// - Priority, same cycle: reset > pacman_died > game_start > ghost_eaten > power_pellet > timer expiry.
// - pacman_died (not IDLE) or game_start: -> JAIL, phase 0, counters 0, frightened 0, no pulse.
// - power_pellet coincident with fright expiry: pellet wins, fright restarts full length.
// - Second counters 5 bits; parameters must be 1..31.
// TESTING (TICKS_PER_SEC=4, JAIL 2, SCATTER 3, CHASE 5, FRIGHT 2, NUM_PAIRS 2)
// 1. game_start -> GhostMode 00 for 8 cycles, 01 for 12, then 10 with one mode_changed pulse, 20 cycles.
// 2. Run 2 full pairs -> phase=4, GhostMode stays 10 for 200+ cycles, no further pulses.
// 3. power_pellet 12 cycles into CHASE -> frightened=1 for 8 cycles + pulse; chase then ends 8 cycles later.
// 4. ghost_eaten while frightened -> 11 next cycle; ghost_in_jail after 5 -> 00 for 8 -> 10, remaining time.
// 5. pacman_died + power_pellet same cycle in SCATTER -> 00, phase 0, frightened 0, no pulse.
// 6. Assert reset mid-fright between edges -> all outputs at reset values immediately; IDLE holds.

Source files
------------

// File: rtl/ghost_mode_timer.sv
`default_nettype none
// ghost_mode_timer: per-second scatter/chase/jail schedule with frightened overlay
// and direction-reverse pulse, feeding the GhostMode code of ghost_mode. Rev 1.0
module ghost_mode_timer #(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int JAIL_SEC       = 3,
    parameter int SCATTER_SEC    = 7,
    parameter int SCATTER_SEC_L1 = 5,
    parameter int CHASE_SEC      = 20,
    parameter int FRIGHT_SEC     = 6,
    parameter int FRIGHT_SEC_L1  = 3,
    parameter int NUM_PAIRS      = 4
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       game_start,
    input  logic       level,
    input  logic       power_pellet,
    input  logic       ghost_eaten,
    input  logic       ghost_in_jail,
    input  logic       pacman_died,
    output logic [1:0] GhostMode,
    output logic       frightened,
    output logic       mode_changed,
    output logic [3:0] phase
);
    localparam int              PW          = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]      PHASE_END   = 4'(2 * NUM_PAIRS);
    localparam logic [4:0]      JAIL_LAST   = 5'(JAIL_SEC - 1);
    localparam logic [4:0]      SCAT_LAST   = 5'(SCATTER_SEC - 1);
    localparam logic [4:0]      SCAT1_LAST  = 5'(SCATTER_SEC_L1 - 1);
    localparam logic [4:0]      CHASE_LAST  = 5'(CHASE_SEC - 1);
    localparam logic [4:0]      FRT_LAST    = 5'(FRIGHT_SEC - 1);
    localparam logic [4:0]      FRT1_LAST   = 5'(FRIGHT_SEC_L1 - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_JAIL    = 3'd1,
        S_SCATTER = 3'd2,
        S_CHASE   = 3'd3,
        S_RETURN  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [4:0]    sched_sec, sched_next;   // schedule seconds, frozen while frightened/returning
    logic [4:0]    aux_sec, aux_next;       // jail or fright seconds (never both at once)
    logic [3:0]    phase_next;
    logic          fright_next, pulse_next, level_q, level_next;
    logic [1:0]    mode_next;

    logic       tick, timed, sched_run, sched_last, fright_last, jail_last;
    logic [4:0] sched_len_last;

    assign tick           = (presc == PRESC_MAX);
    assign timed          = (phase != PHASE_END);
    assign sched_len_last = (state == S_SCATTER) ? (level_q ? SCAT1_LAST : SCAT_LAST) : CHASE_LAST;
    assign sched_run      = ((state == S_SCATTER) || (state == S_CHASE)) && !frightened && timed;
    assign sched_last     = (sched_sec == sched_len_last);
    assign fright_last    = (aux_sec == (level_q ? FRT1_LAST : FRT_LAST));
    assign jail_last      = (aux_sec == JAIL_LAST);

    always_comb begin
        state_next  = state;
        phase_next  = phase;
        sched_next  = sched_sec;
        aux_next    = aux_sec;
        presc_next  = tick ? '0 : presc + PW'(1);
        fright_next = frightened;
        pulse_next  = 1'b0;
        level_next  = level_q;

        if (game_start || (pacman_died && state != S_IDLE)) begin
            state_next  = S_JAIL;
            phase_next  = '0;
            sched_next  = '0;
            aux_next    = '0;
            presc_next  = '0;
            fright_next = 1'b0;
            if (game_start) level_next = level;
        end else begin
            case (state)
                S_IDLE: presc_next = '0;
                S_JAIL: begin
                    if (tick) aux_next = aux_sec + 5'd1;
                    if (tick && jail_last) begin
                        state_next = (!phase[0] && timed) ? S_SCATTER : S_CHASE;
                        aux_next   = '0;
                    end
                end
                S_SCATTER, S_CHASE: begin
                    if (ghost_eaten && frightened) begin
                        state_next  = S_RETURN;
                        fright_next = 1'b0;
                        aux_next    = '0;
                        presc_next  = '0;
                    end else if (power_pellet) begin
                        fright_next = 1'b1;
                        aux_next    = '0;
                        presc_next  = '0;
                        pulse_next  = 1'b1;
                        // A second completing on this edge still counts; only expiry is pre-empted.
                        if (sched_run && tick && !sched_last) sched_next = sched_sec + 5'd1;
                    end else if (frightened) begin
                        if (tick) begin
                            if (fright_last) begin
                                fright_next = 1'b0;
                                aux_next    = '0;
                            end else begin
                                aux_next = aux_sec + 5'd1;
                            end
                        end
                    end else if (sched_run && tick) begin
                        if (sched_last) begin
                            sched_next = '0;
                            phase_next = phase + 4'd1;
                            // Final chase rolls into permanent chase: mode unchanged, so no reversal.
                            if (state == S_SCATTER) begin
                                state_next = S_CHASE;
                                pulse_next = 1'b1;
                            end else if (phase + 4'd1 != PHASE_END) begin
                                state_next = S_SCATTER;
                                pulse_next = 1'b1;
                            end
                        end else begin
                            sched_next = sched_sec + 5'd1;
                        end
                    end
                end
                S_RETURN: begin
                    presc_next = '0;
                    if (ghost_in_jail) begin
                        state_next = S_JAIL;
                        aux_next   = '0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_next)
            S_SCATTER: mode_next = 2'b01;
            S_CHASE:   mode_next = 2'b10;
            S_RETURN:  mode_next = 2'b11;
            default:   mode_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            sched_sec    <= '0;
            aux_sec      <= '0;
            phase        <= '0;
            frightened   <= 1'b0;
            mode_changed <= 1'b0;
            GhostMode    <= 2'b00;
            level_q      <= 1'b0;
        end else begin
            presc        <= presc_next;
            sched_sec    <= sched_next;
            aux_sec      <= aux_next;
            phase        <= phase_next;
            frightened   <= fright_next;
            mode_changed <= pulse_next;
            GhostMode    <= mode_next;
            level_q      <= level_next;
        end
    end
endmodule
`default_nettype wire
